// File: rtl/cavlc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cavlc_pkg : shared state encoding and code widths for the CAVLC encoder
// Revision  : 1.0
// ---------------------------------------------------------------------------
package cavlc_pkg;
    localparam int CODE_W = 16;
    localparam int LEN_W  = 5;
    localparam int BITS_W = 10;

    typedef enum logic [2:0] {
        WAIT_ENABLE  = 3'd0,
        COEFF_TOKEN  = 3'd1,
        LEVEL_ENCODE = 3'd2,
        ZERO_ENCODE  = 3'd3,
        DONE         = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/cavlc_enc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cavlc_enc_ctrl : sequences coeff_token, level and zero codes to the packer
// Revision       : 1.0
// ---------------------------------------------------------------------------
module cavlc_enc_ctrl
    import cavlc_pkg::*;
(
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Enable,
    input  logic [4:0]        TotalCoeff,
    input  logic [4:0]        MaxNumCoeff,
    input  logic [CODE_W-1:0] CtCode,
    input  logic [LEN_W-1:0]  CtLen,
    input  logic              CtValid,
    input  logic [CODE_W-1:0] LvCode,
    input  logic [LEN_W-1:0]  LvLen,
    input  logic              LvValid,
    input  logic [CODE_W-1:0] ZrCode,
    input  logic [LEN_W-1:0]  ZrLen,
    input  logic              ZrValid,
    input  logic              ZrLast,
    input  logic              PackReady,
    output logic              PackEn,
    output logic [CODE_W-1:0] PackCode,
    output logic [LEN_W-1:0]  PackLen,
    output logic              CodeAck,
    output logic              CoeffTokenEncodeEnable,
    output logic              LevelEncodeEnable,
    output logic              ZeroEncodeEnable,
    output logic              Busy,
    output logic              BlockDone,
    output logic [BITS_W-1:0] BlockBits
);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  total_coeff;
    logic [4:0]  max_coeff;
    logic [4:0]  level_cnt;
    logic [4:0]  total_clamped;
    logic        accept;
    logic        level_last;

    assign total_clamped = (TotalCoeff > MaxNumCoeff) ? MaxNumCoeff : TotalCoeff;
    assign accept        = PackEn & PackReady;
    assign CodeAck       = accept;
    assign level_last    = (level_cnt == total_coeff - 5'd1);

    assign CoeffTokenEncodeEnable = (state == COEFF_TOKEN);
    assign LevelEncodeEnable      = (state == LEVEL_ENCODE);
    assign ZeroEncodeEnable       = (state == ZERO_ENCODE);
    assign Busy                   = (state != WAIT_ENABLE);
    assign BlockDone              = (state == DONE);

    always_comb begin
        PackEn   = 1'b0;
        PackCode = '0;
        PackLen  = '0;
        case (state)
            COEFF_TOKEN: begin
                PackEn   = CtValid;
                PackCode = CtCode;
                PackLen  = CtLen;
            end
            LEVEL_ENCODE: begin
                PackEn   = LvValid;
                PackCode = LvCode;
                PackLen  = LvLen;
            end
            ZERO_ENCODE: begin
                PackEn   = ZrValid;
                PackCode = ZrCode;
                PackLen  = ZrLen;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_ENABLE:  if (Enable) state_nxt = COEFF_TOKEN;
            COEFF_TOKEN:  if (accept) state_nxt = (total_coeff == 5'd0) ? DONE : LEVEL_ENCODE;
            LEVEL_ENCODE: if (accept && level_last)
                              state_nxt = (total_coeff == max_coeff) ? DONE : ZERO_ENCODE;
            ZERO_ENCODE:  if (accept && ZrLast) state_nxt = DONE;
            DONE:         state_nxt = WAIT_ENABLE;
            default:      state_nxt = WAIT_ENABLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= WAIT_ENABLE;
            total_coeff <= '0;
            max_coeff   <= '0;
            level_cnt   <= '0;
            BlockBits   <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_ENABLE && Enable) begin
                total_coeff <= total_clamped;
                max_coeff   <= MaxNumCoeff;
                level_cnt   <= '0;
                BlockBits   <= '0;
            end else if (accept) begin
                BlockBits <= BlockBits + BITS_W'(PackLen);
                if (state == LEVEL_ENCODE)
                    level_cnt <= level_cnt + 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cavlc_enc_ctrl.md
CAVLC_ENC_CTRL -- requirements
Module: cavlc_enc_ctrl

Interface
REQ-001 Clk  in  1  single clock; all state changes on its rising edge.
REQ-002 nReset  in  1  asynchronous, active-low reset.
REQ-003 Enable  in  1  start request; sampled only in WAIT_ENABLE.
REQ-004 TotalCoeff  in  5  nonzero-coefficient count of the block; sampled with Enable.
REQ-005 MaxNumCoeff  in  5  block coefficient capacity (4, 15 or 16); sampled with Enable.
REQ-006 CtCode/CtLen/CtValid  in  16/5/1  coeff_token code from the token encoder.
REQ-007 LvCode/LvLen/LvValid  in  16/5/1  level (incl. trailing-one sign) code from the level encoder.
REQ-008 ZrCode/ZrLen/ZrValid/ZrLast  in  16/5/1/1  total_zeros/run_before code; ZrLast marks the final zero code.
REQ-009 PackReady  in  1  bit packer can accept a code this cycle.
REQ-010 PackEn/PackCode/PackLen  out  1/16/5  code to the bit packer.
REQ-011 CodeAck  out  1  pulse: the currently selected encoder's code was accepted.
REQ-012 CoeffTokenEncodeEnable/LevelEncodeEnable/ZeroEncodeEnable  out  1 each  encoder enables.
REQ-013 Busy  out  1  high in any state other than WAIT_ENABLE.
REQ-014 BlockDone  out  1  one-cycle pulse at block end.
REQ-015 BlockBits  out  10  total bits emitted for the last or current block.

Function
REQ-016 States: WAIT_ENABLE, COEFF_TOKEN, LEVEL_ENCODE, ZERO_ENCODE, DONE.
REQ-017 WAIT_ENABLE: on Enable=1, register TotalCoeff (clamped to MaxNumCoeff) and MaxNumCoeff, clear BlockBits and LevelCount, then go to COEFF_TOKEN; otherwise stay.
REQ-018 Code mux: COEFF_TOKEN selects Ct*, LEVEL_ENCODE selects Lv*, ZERO_ENCODE selects Zr*; other states drive PackEn=0 and PackCode/PackLen=0.
REQ-019 PackEn = selected Valid; PackCode/PackLen = selected Code/Len, combinational with zero added latency.
REQ-020 Accept = PackEn & PackReady; CodeAck = Accept in the same cycle.
REQ-021 With Valid=1 and PackReady=0, the FSM holds state and the code is not accepted; the encoder holds its code stable until it is acknowledged.
REQ-022 On every Accept, BlockBits increases by PackLen; the 10-bit width cannot overflow for legal blocks (max 16+256+9+15*11 bits).
REQ-023 COEFF_TOKEN: on Accept, go to DONE if the registered TotalCoeff=0, else to LEVEL_ENCODE.
REQ-024 LEVEL_ENCODE: each Accept increments the 5-bit LevelCount.
REQ-025 LEVEL_ENCODE: on the Accept where LevelCount=TotalCoeff-1, go to DONE if TotalCoeff=MaxNumCoeff, else to ZERO_ENCODE.
REQ-026 ZERO_ENCODE: on an Accept with ZrLast=1, go to DONE; an Accept without ZrLast stays in ZERO_ENCODE.
REQ-027 DONE: BlockDone=1 for exactly this one cycle; next state is WAIT_ENABLE unconditionally.
REQ-028 BlockBits is stable from DONE until the next accepted Enable.
REQ-029 The encoder enables are a combinational decode of the current state: COEFF_TOKEN, LEVEL_ENCODE, ZERO_ENCODE respectively.
REQ-030 Enable is ignored outside WAIT_ENABLE; deasserting it mid-block does not abort the block.
REQ-031 The earliest restart is the cycle after DONE; a new Enable in that cycle starts the next block with no bubble.
REQ-032 An unreachable state encoding returns to WAIT_ENABLE on the next clock.

Reset
REQ-033 On nReset=0: state=WAIT_ENABLE, LevelCount=0, BlockBits=0, registered TotalCoeff/MaxNumCoeff=0.
REQ-034 During reset all outputs are 0: PackEn, CodeAck, all enables, Busy, BlockDone, BlockBits.
REQ-035 Reset asserted mid-block aborts the block immediately, with no BlockDone pulse.

Structure
REQ-036 The shared package cavlc_pkg holds the state enum and the constants CODE_W=16, LEN_W=5, BITS_W=10.
REQ-037 The block is a single module with no sub-module; the bit packer and the encoders are external peers.

Verification
REQ-038 Scenario: TotalCoeff=0, MaxNumCoeff=16, Ct len 1, PackReady=1 -> sequence WAIT, CT, DONE; BlockDone 2 cycles after Enable; BlockBits=1.
REQ-039 Scenario: TotalCoeff=3, Max=16, Ct len 5, three Lv codes of len 1/1/3, Zr codes len 4/2 (ZrLast on the 2nd), PackReady=1 -> 6 CodeAcks; BlockBits=16; BlockDone once.
REQ-040 Scenario: TotalCoeff=16, Max=16 -> ZERO_ENCODE skipped; DONE follows the 16th level Accept; ZeroEncodeEnable never asserts.
REQ-041 Scenario: PackReady held 0 for 3 cycles with LvValid=1 -> no CodeAck, LevelCount and BlockBits unchanged, PackCode stable; Accept on the 4th cycle.
REQ-042 Scenario: TotalCoeff=9 with Max=4 -> clamped to 4; 4 level codes then DONE (ZERO_ENCODE skipped).
REQ-043 Scenario: nReset pulsed while in LEVEL_ENCODE; also Enable held high across DONE -> reset: all outputs 0, no BlockDone; Enable case: next block starts the cycle after DONE.
